// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32 front end: fetch FSM states, the canonical NOP,
// and helpers that validate queue depth and address width at elaboration.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic bit isPow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit depthLegal(input int unsigned depth);
        return (depth >= 2) && isPow2(depth);
    endfunction

    function automatic bit xlenLegal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction-queue storage with push, pop, flush and an occupancy count.
// Push and pop may coincide at any occupancy, including full; flush wins over both.
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wrPtr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues word fetches under a queue credit check, tags them
// with an epoch so redirects discard stale responses, and buffers words in ifq_fifo.
module ifetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [XLEN-1:0]            imemaddr,
    output logic                       imemreq,
    input  logic [31:0]                imemdataout,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import rv32_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (!depthLegal(DEPTH)) begin : gDepthCheck
        $error("ifetch_queue: DEPTH must be a power of two and at least 2");
    end
    if (!xlenLegal(XLEN)) begin : gXlenCheck
        $error("ifetch_queue: XLEN must be 32 or 64");
    end
    if (RESET_PC[1:0] != 2'b00) begin : gResetPcCheck
        $error("ifetch_queue: RESET_PC must be word aligned");
    end

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] reqPc_q, reqPc_d;
    logic            epoch_q, epoch_d;
    logic            reqEpoch_q, reqEpoch_d;
    logic            inflight_q, inflight_d;

    logic             push;
    logic             pop;
    logic             creditOk;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W:0]   limit;
    logic [XLEN+31:0] fifoRdata;
    logic             unusedPcBits;

    assign unusedPcBits = ^redirect_pc[1:0];

    // out_valid comes from the registered count only, never from the memory data path.
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = inflight_q && (reqEpoch_q == epoch_q) && !redirect;

    // A new request is allowed if the queue can still hold it after this cycle's pop.
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q);
    assign limit     = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
    assign creditOk  = occupancy < limit;

    assign imemreq  = (state_q == RUN) && creditOk && !redirect;
    assign imemaddr = pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (!redirect && !creditOk) state_d = STALL;
            STALL:   if (redirect || creditOk) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Each request records its PC and epoch; a redirect bumps the epoch so that
    // any response still tagged with the old epoch is never pushed.
    always_comb begin
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        reqPc_d    = reqPc_q;
        reqEpoch_d = reqEpoch_q;
        inflight_d = imemreq;
        if (redirect) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            epoch_d = ~epoch_q;
        end else if (imemreq) begin
            pc_d       = pc_q + XLEN'(4);
            reqPc_d    = pc_q;
            reqEpoch_d = epoch_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            reqPc_q    <= '0;
            epoch_q    <= 1'b0;
            reqEpoch_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            reqPc_q    <= reqPc_d;
            epoch_q    <= epoch_d;
            reqEpoch_q <= reqEpoch_d;
            inflight_q <= inflight_d;
        end
    end

    ifq_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({reqPc_q, imemdataout}),
        .rdata_o (fifoRdata),
        .count_o (count)
    );

    assign out_pc    = fifoRdata[XLEN+31:32];
    assign out_instr = fifoRdata[31:0];

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/address width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries; power of 2, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address; bits [1:0] zero.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imemaddr  output  XLEN  fetch address, word-aligned.
REQ-007 SHALL have port imemreq  output  1  fetch request; memory returns the word one cycle later.
REQ-008 SHALL have port imemdataout  input  32  instruction word, valid the cycle after imemreq.
REQ-009 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  XLEN  new fetch target; bits [1:0] ignored.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  core accepts the head entry.
REQ-013 SHALL have port out_instr  output  32  head instruction.
REQ-014 SHALL have port out_pc  output  XLEN  PC of the head instruction.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL pop the head on a rising edge with out_valid=1 and out_ready=1.
REQ-017 SHALL drive imemreq=1 only while RUN and count + inflight - pop < DEPTH; inflight is at most 1.
REQ-018 SHALL advance fetch PC by 4 per issued request, modulo 2^XLEN; 0xFFFFFFFC wraps to 0.
REQ-019 SHALL tag each request with its PC and the current epoch bit; the response is pushed with that PC if its epoch matches, else dropped.
REQ-020 SHALL accept a push and a pop in the same cycle at any count, including full, with count unchanged.
REQ-021 SHALL present entries in FIFO order, with out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on redirect=1, take priority over push and pop, clear the queue to count=0, toggle epoch, and load fetch PC with {redirect_pc[XLEN-1:2],2'b00}; the first request to the new PC issues in the following cycle.
REQ-023 SHALL hold redirect for one cycle only; back-to-back redirects each flush, and the last target wins.
REQ-024 SHALL implement FSM IDLE -> RUN on the first edge after reset release.
REQ-025 SHALL move RUN -> STALL when the credit check fails; STALL -> RUN when credit is returned or on redirect.
REQ-026 SHALL drive imemreq=0 in IDLE and STALL.
REQ-027 SHALL have zero-bubble throughput: with out_ready held 1, one instruction per cycle after a 2-cycle startup latency (request, response/push, visible at head the same cycle as push).
REQ-028 SHALL derive out_valid from count != 0 only; no combinational path from imemdataout to out_valid.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: FSM=IDLE, fetch PC=RESET_PC, count=0, inflight=0, epoch=0, imemreq=0, imemaddr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
REQ-030 SHALL, on reset asserted mid-operation, discard queued and in-flight data; the response arriving after release is ignored.

Structure
REQ-031 SHALL place DEPTH/XLEN legality checks, the FSM state enum (IDLE, RUN, STALL) and the NOP constant 32'h00000013 in a shared package rv32_pkg.
REQ-032 SHALL use one sub-module, ifq_fifo (parametrised storage with push/pop/flush and count); credit, epoch and FSM logic stay in ifetch_queue.

Verification
REQ-033 SHALL cover reset: reset=0 at time 0, released at 10 -> imemaddr=0, out_valid=0; first imemreq at the first edge after release.
REQ-034 SHALL cover streaming: words 0x06400313, 0x00602023, 0x01400393 returned, out_ready=1 -> out_pc 0,4,8 with matching out_instr on consecutive cycles.
REQ-035 SHALL cover backpressure: DEPTH=4, out_ready=0 -> count reaches 4, imemreq=0, FSM=STALL; one pop -> exactly one new request.
REQ-036 SHALL cover redirect: redirect=1, redirect_pc=0x103 during an in-flight fetch of 0x0C -> count=0, stale word dropped, next imemaddr=0x100.
REQ-037 SHALL cover full simultaneity: full queue, push and pop in one cycle -> count stays 4, order preserved.
REQ-038 SHALL cover wrap: redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
